inst_rom_loader: RTL and testbench

//  Instruction-memory responder for the Hack CPU's ROM port: returns inst for inst_addr every cycle.

---
 rtl/hack_pkg.sv | 27 ++
 rtl/inst_rom_loader_if.sv | 9 +
 rtl/inst_rom.sv | 26 ++
 rtl/inst_rom_loader.sv | 162 ++++++++++++++++
 tb/tb_inst_rom_loader.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack instruction-ROM loader.
// boot_word() defines the power-up program image held by the instruction ROM.
package hack_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_FINISH
  } loader_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_TIMEOUT = 2'd2
  } load_err_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 2;

  function automatic logic [15:0] boot_word(input logic [7:0] a);
    return {~a, a};
  endfunction

endpackage

// File: rtl/inst_rom_loader_if.sv
// Byte-stream handshake from the UART receiver into the loader.
interface inst_rom_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/inst_rom.sv
// Instruction store: one synchronous write port, one combinational read port.
// Cells hold the difference from the boot image, so zero-initialised storage reads as boot_word().
module inst_rom
  import hack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32768,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata ^ WIDTH'(boot_word(waddr[7:0]));
  end

  assign rdata = mem_q[raddr] ^ WIDTH'(boot_word(raddr[7:0]));

endmodule

// File: rtl/inst_rom_loader.sv
// Hack CPU instruction ROM with an in-system byte-stream loader that holds the CPU in reset while loading.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_RUN     | CPU running from ROM, loader idle
// ST_LEN_HI  | waiting for length MSB
// ST_LEN_LO  | waiting for length LSB, then range check
// ST_DATA_HI | waiting for instruction high byte
// ST_DATA_LO | waiting for instruction low byte, writes the word
// ST_FINISH  | one-cycle load_done pulse, CPU still in reset
module inst_rom_loader
  import hack_pkg::*;
#(
  parameter int INSTR_WIDTH    = 16,
  parameter int ROM_DEPTH      = 32768,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic [INSTR_WIDTH-1:0] inst_addr,
  output logic [INSTR_WIDTH-1:0] inst,
  input  logic                   load_start,
  inst_rom_loader_if.slave       rx,
  output logic                   cpu_resetN,
  output logic                   load_busy,
  output logic                   load_done,
  output load_err_t              load_err
);

  localparam int AW    = $clog2(ROM_DEPTH);
  localparam int LEN_W = 8 * LEN_BYTES;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_RELOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LEN_W:0] MAX_LEN    = (LEN_W + 1)'(ROM_DEPTH);

  if (INSTR_WIDTH != 8 * BYTES_PER_WORD) begin : g_bad_width
    $error("inst_rom_loader: INSTR_WIDTH must be two bytes");
  end

  loader_state_t    state;
  logic [AW-1:0]    addr;
  logic [LEN_W-1:0] remaining;
  logic [7:0]       len_hi;
  logic [7:0]       data_hi;
  logic [TW-1:0]    tmo;
  logic             accept;
  logic             rom_we;
  logic [LEN_W-1:0] len_word;
  logic             unused_addr;

  assign accept      = rx.rx_valid && rx.rx_ready;
  assign rom_we      = resetN && accept && (state == ST_DATA_LO);
  assign len_word    = {len_hi, rx.rx_data};
  assign unused_addr = ^inst_addr;

  inst_rom #(
    .WIDTH (INSTR_WIDTH),
    .DEPTH (ROM_DEPTH)
  ) u_rom (
    .clk   (clk),
    .we    (rom_we),
    .waddr (addr),
    .wdata ({data_hi, rx.rx_data}),
    .raddr (inst_addr[AW-1:0]),
    .rdata (inst)
  );

  // tmo is a down-counter: reloaded on every accepted byte, abort when it hits zero idle
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= ST_RUN;
      cpu_resetN  <= 1'b0;
      rx.rx_ready <= 1'b0;
      load_busy   <= 1'b0;
      load_done   <= 1'b0;
      load_err    <= ERR_NONE;
      addr        <= '0;
      remaining   <= '0;
      len_hi      <= '0;
      data_hi     <= '0;
      tmo         <= '0;
    end else begin
      load_done <= 1'b0;
      case (state)
        ST_RUN: begin
          cpu_resetN <= 1'b1;
          if (load_start) begin
            state       <= ST_LEN_HI;
            load_err    <= ERR_NONE;
            addr        <= '0;
            tmo         <= TMO_RELOAD;
            rx.rx_ready <= 1'b1;
            load_busy   <= 1'b1;
            cpu_resetN  <= 1'b0;
          end
        end
        ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO: begin
          if (accept) begin
            tmo <= TMO_RELOAD;
            case (state)
              ST_LEN_HI: begin
                len_hi <= rx.rx_data;
                state  <= ST_LEN_LO;
              end
              ST_LEN_LO: begin
                if (len_word == '0) begin
                  state       <= ST_FINISH;
                  rx.rx_ready <= 1'b0;
                  load_done   <= 1'b1;
                end else if ({1'b0, len_word} > MAX_LEN) begin
                  state       <= ST_RUN;
                  load_err    <= ERR_LEN;
                  rx.rx_ready <= 1'b0;
                  load_busy   <= 1'b0;
                  cpu_resetN  <= 1'b1;
                end else begin
                  remaining <= len_word;
                  state     <= ST_DATA_HI;
                end
              end
              ST_DATA_HI: begin
                data_hi <= rx.rx_data;
                state   <= ST_DATA_LO;
              end
              default: begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
                if (remaining == LEN_W'(1)) begin
                  state       <= ST_FINISH;
                  rx.rx_ready <= 1'b0;
                  load_done   <= 1'b1;
                end else begin
                  state <= ST_DATA_HI;
                end
              end
            endcase
          end else if (tmo == '0) begin
            state       <= ST_RUN;
            load_err    <= ERR_TIMEOUT;
            rx.rx_ready <= 1'b0;
            load_busy   <= 1'b0;
            cpu_resetN  <= 1'b1;
          end else begin
            tmo <= tmo - 1'b1;
          end
        end
        ST_FINISH: begin
          state      <= ST_RUN;
          load_busy  <= 1'b0;
          cpu_resetN <= 1'b1;
        end
        default: begin
          state       <= ST_RUN;
          rx.rx_ready <= 1'b0;
          load_busy   <= 1'b0;
          cpu_resetN  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: hand vectors for the directed cases plus
// randomized byte streams checked cycle by cycle against a byte-counting reference model.
module tb_inst_rom_loader;

  localparam int DEPTH = 32768;
  localparam int T     = 50;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        load_start = 1'b0;
  logic [15:0] inst_addr = '0;
  logic [15:0] inst;
  logic        cpu_resetN, load_busy, load_done;
  logic [1:0]  load_err;

  inst_rom_loader_if rx_if ();

  inst_rom_loader #(
    .INSTR_WIDTH    (16),
    .ROM_DEPTH      (DEPTH),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk        (clk),
    .resetN     (resetN),
    .inst_addr  (inst_addr),
    .inst       (inst),
    .load_start (load_start),
    .rx         (rx_if),
    .cpu_resetN (cpu_resetN),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: loader described as a count of bytes received in the current load.
  logic [15:0] m_rom [DEPTH];
  bit          m_active, m_finish, m_cpu, m_done;
  int          m_err, m_nbytes, m_len, m_idle;
  logic [7:0]  m_hi_byte;
  bit          acc;

  function automatic logic [15:0] boot(input int a);
    return 16'((((~a) & 'hff) << 8) | (a & 'hff));
  endfunction

  task automatic model_edge(input bit start, input bit valid, input logic [7:0] d,
                            input bit rstn, output bit accepted);
    int w;
    accepted = 1'b0;
    if (!rstn) begin
      m_active = 0; m_finish = 0; m_cpu = 0; m_done = 0;
      m_err = 0; m_idle = 0; m_nbytes = 0;
      return;
    end
    m_done = 0;
    if (m_finish) begin
      m_finish = 0;
      m_cpu    = 1;
    end else if (!m_active) begin
      m_cpu = 1;
      if (start) begin
        m_active = 1; m_err = 0; m_nbytes = 0; m_idle = 0; m_cpu = 0;
      end
    end else if (valid) begin
      accepted = 1'b1;
      m_idle   = 0;
      m_nbytes++;
      if (m_nbytes == 1) begin
        m_len = int'(d) << 8;
      end else if (m_nbytes == 2) begin
        m_len += int'(d);
        if (m_len == 0) begin
          m_active = 0; m_finish = 1; m_done = 1;
        end else if (m_len > DEPTH) begin
          m_active = 0; m_err = 1; m_cpu = 1;
        end
      end else if (m_nbytes % 2 == 1) begin
        m_hi_byte = d;
      end else begin
        w = (m_nbytes - 2) / 2 - 1;
        m_rom[w] = {m_hi_byte, d};
        if (w + 1 == m_len) begin
          m_active = 0; m_finish = 1; m_done = 1;
        end
      end
    end else begin
      m_idle++;
      if (m_idle == T) begin
        m_active = 0; m_err = 2; m_cpu = 1;
      end
    end
  endtask

  task automatic tick(input bit start, input bit valid, input logic [7:0] d,
                      input bit rstn, output bit accepted);
    load_start      = start;
    rx_if.rx_valid  = valid;
    rx_if.rx_data   = d;
    resetN          = rstn;
    model_edge(start, valid, d, rstn, accepted);
    @(posedge clk);
    #1;
    load_start     = 1'b0;
    rx_if.rx_valid = 1'b0;
    resetN         = 1'b1;
    chk("rx_ready",   rx_if.rx_ready, m_active);
    chk("load_busy",  load_busy,      m_active | m_finish);
    chk("cpu_resetN", cpu_resetN,     m_cpu);
    chk("load_done",  load_done,      m_done);
    chk("load_err",   load_err,       m_err);
  endtask

  task automatic check_inst(input int a);
    inst_addr = a[15:0];
    #1;
    chk($sformatf("inst[%0h]", a), inst, m_rom[a % DEPTH]);
  endtask

  task automatic send(input logic [7:0] d);
    tick(0, 1, d, 1, acc);
  endtask

  task automatic run_random(input int nwords, input int reset_at);
    logic [7:0] q[$];
    bit         start, valid, rstn;
    logic [7:0] d;
    q.push_back(8'(nwords >> 8));
    q.push_back(8'(nwords));
    for (int i = 0; i < 2 * nwords; i++) q.push_back(8'($urandom));
    for (int c = 0; c < 800; c++) begin
      if (c > 0 && q.size() == 0 && !m_active && !m_finish) break;
      if (c > 0 && !m_active && !m_finish) break;
      start = (c == 0) || (m_active && $urandom_range(0, 15) == 0);
      rstn  = (c != reset_at);
      valid = (q.size() > 0) && ($urandom_range(0, 3) != 0);
      d     = valid ? q[0] : 8'($urandom);
      tick(start, valid, d, rstn, acc);
      if (acc) void'(q.pop_front());
      if (!rstn) q.delete();
      if (c % 8 == 7) check_inst($urandom_range(0, 40));
    end
    chk("rand_busy_end", load_busy, 0);
    for (int a = 0; a < nwords + 2; a++) check_inst(a);
    for (int i = 0; i < 4; i++) check_inst($urandom_range(0, 40) | 32768);
  endtask

  typedef struct {
    bit         start;
    bit         valid;
    logic [7:0] d;
    bit         ready;
    bit         busy;
    bit         cpu;
    bit         done;
  } vec_t;

  vec_t tbl[10];

  initial begin
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = '0;
    for (int i = 0; i < DEPTH; i++) m_rom[i] = boot(i);

    // reset and boot image
    tick(0, 0, 8'h00, 0, acc);
    chk("rst_cpu_low", cpu_resetN, 0);
    chk("rst_busy", load_busy, 0);
    inst_addr = 16'd5;
    #1;
    chk("boot_inst5", inst, 16'hFA05);
    tick(0, 0, 8'h00, 1, acc);
    chk("rst_cpu_release", cpu_resetN, 1);

    // two-word load, hand-derived per-cycle outputs
    tbl[0] = '{1, 0, 8'h00, 1, 1, 0, 0};
    tbl[1] = '{0, 1, 8'h00, 1, 1, 0, 0};
    tbl[2] = '{0, 1, 8'h02, 1, 1, 0, 0};
    tbl[3] = '{0, 1, 8'hEC, 1, 1, 0, 0};
    tbl[4] = '{0, 1, 8'h10, 1, 1, 0, 0};
    tbl[5] = '{0, 0, 8'h55, 1, 1, 0, 0};
    tbl[6] = '{0, 1, 8'hE3, 1, 1, 0, 0};
    tbl[7] = '{0, 1, 8'h08, 0, 1, 0, 1};
    tbl[8] = '{0, 0, 8'h00, 0, 0, 1, 0};
    tbl[9] = '{0, 0, 8'h00, 0, 0, 1, 0};
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].start, tbl[i].valid, tbl[i].d, 1, acc);
      chk($sformatf("tbl%0d_ready", i), rx_if.rx_ready, tbl[i].ready);
      chk($sformatf("tbl%0d_busy", i),  load_busy,      tbl[i].busy);
      chk($sformatf("tbl%0d_cpu", i),   cpu_resetN,     tbl[i].cpu);
      chk($sformatf("tbl%0d_done", i),  load_done,      tbl[i].done);
      chk($sformatf("tbl%0d_err", i),   load_err,       0);
    end
    inst_addr = 16'd0; #1; chk("load2_w0", inst, 16'hEC10);
    inst_addr = 16'd1; #1; chk("load2_w1", inst, 16'hE308);

    // zero-length load
    tick(1, 0, 8'h00, 1, acc);
    send(8'h00);
    send(8'h00);
    chk("len0_done", load_done, 1);
    tick(0, 0, 8'h00, 1, acc);
    chk("len0_run", load_busy, 0);
    inst_addr = 16'd0; #1; chk("len0_rom", inst, 16'hEC10);

    // oversize length
    tick(1, 0, 8'h00, 1, acc);
    send(8'h80);
    send(8'h01);
    chk("len_err", load_err, 1);
    chk("len_err_busy", load_busy, 0);
    chk("len_err_done", load_done, 0);
    tick(0, 0, 8'h00, 1, acc);
    inst_addr = 16'd1; #1; chk("len_err_rom", inst, 16'hE308);

    // timeout after a partial load
    tick(1, 0, 8'h00, 1, acc);
    send(8'h00); send(8'h03); send(8'hEC); send(8'h10);
    for (int i = 0; i < T - 1; i++) tick(0, 0, 8'h00, 1, acc);
    chk("tmo_still_busy", load_busy, 1);
    tick(0, 0, 8'h00, 1, acc);
    chk("tmo_err", load_err, 2);
    chk("tmo_run", load_busy, 0);
    chk("tmo_cpu", cpu_resetN, 1);
    inst_addr = 16'd0; #1; chk("tmo_w0", inst, 16'hEC10);
    inst_addr = 16'd1; #1; chk("tmo_w1", inst, 16'hE308);
    inst_addr = 16'd2; #1; chk("tmo_w2", inst, 16'hFD02);

    // randomized streams with gaps, stray load_start and a mid-load reset
    run_random(20, -1);
    run_random(30, 25 + $urandom_range(0, 30));
    run_random(5, -1);
    run_random(12, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
